// File: rtl/wt_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module : wt_cache_pkg
// Brief  : Shared types and sizing constants for the write-through L1 dcache.
// Rev    : 1.0  initial release
// ============================================================================
package wt_cache_pkg;

  localparam int unsigned DCACHE_REQ_BUF_DEPTH   = 2;
  localparam int unsigned DCACHE_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ   = 2'd0,
    DCACHE_STORE_REQ  = 2'd1,
    DCACHE_ATOMIC_REQ = 2'd2,
    DCACHE_INT_REQ    = 2'd3
  } dcache_out_t;

  typedef struct packed {
    dcache_out_t  rtype;
    logic [2:0]   size;
    logic [3:0]   id;
    logic [31:0]  paddr;
    logic [63:0]  data;
    logic         nc;
  } dcache_req_t;

endpackage
`default_nettype wire

// File: rtl/wt_dcache_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : wt_dcache_req_fifo
// Brief  : Depth-entry register FIFO of dcache requests, wrap-bit pointers.
// Rev    : 1.0  initial release
// ============================================================================
module wt_dcache_req_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned Depth = DCACHE_REQ_BUF_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  dcache_req_t data_i,
  input  logic        pop_i,
  output dcache_req_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned c_ADDR_W = (Depth > 1) ? $clog2(Depth) : 1;

  dcache_req_t           r_mem [Depth];
  logic [c_ADDR_W:0]     r_wr_ptr;
  logic [c_ADDR_W:0]     r_rd_ptr;
  logic                  w_push;
  logic                  w_pop;

  // Same index with differing wrap bits means the writer has lapped the reader
  assign full_o  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= data_i;
        r_wr_ptr <= r_wr_ptr + (c_ADDR_W+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (c_ADDR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wt_dcache_req_buffer.sv
`default_nettype none
// ============================================================================
// Module : wt_dcache_req_buffer
// Brief  : Buffers dcache memory requests and caps in-flight transactions.
// Rev    : 1.0  initial release
// ============================================================================
module wt_dcache_req_buffer
  import wt_cache_pkg::*;
#(
  parameter  int unsigned Depth          = DCACHE_REQ_BUF_DEPTH,
  parameter  int unsigned MaxOutstanding = DCACHE_MAX_OUTSTANDING,
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dc_req_i,
  output logic                dc_ack_o,
  input  dcache_req_t         dc_data_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output dcache_req_t         mem_data_o,
  input  logic                mem_rtrn_vld_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] c_MAX_OUT = CntWidth'(MaxOutstanding);

  logic                r_err;
  logic [CntWidth-1:0] r_outstanding;
  logic                w_full;
  logic                w_empty;
  logic                w_ack;
  logic                w_pop;

  wt_dcache_req_fifo #(
    .Depth (Depth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_ack),
    .data_i  (dc_data_i),
    .pop_i   (w_pop),
    .data_o  (mem_data_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Acceptance depends only on registered state so mem_ready_i never reaches dc_ack_o
  assign w_ack = dc_req_i & ~rst_i & ~w_full & (r_outstanding < c_MAX_OUT);
  assign w_pop = ~w_empty & mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_ack && !mem_rtrn_vld_i) begin
        r_outstanding <= r_outstanding + CntWidth'(1);
      end else if (!w_ack && mem_rtrn_vld_i) begin
        if (r_outstanding != '0) begin
          r_outstanding <= r_outstanding - CntWidth'(1);
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign dc_ack_o      = w_ack;
  assign mem_valid_o   = ~w_empty;
  assign outstanding_o = r_outstanding;
  assign busy_o        = ~w_empty | (r_outstanding != '0);
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_req_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_wt_dcache_req_buffer
// Brief  : Directed and randomized self-checking bench for wt_dcache_req_buffer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wt_dcache_req_buffer;
  import wt_cache_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXO  = 4;
  localparam int CW    = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          ack;
  dcache_req_t   dc_data;
  logic          valid;
  logic          ready;
  dcache_req_t   mem_data;
  logic          rtrn;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queue of accepted-but-not-popped payloads, credit count, error flag
  dcache_req_t mq[$];
  int          mcnt = 0;
  bit          merr = 1'b0;

  always #5 clk = ~clk;

  wt_dcache_req_buffer #(
    .Depth          (DEPTH),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dc_req_i       (req),
    .dc_ack_o       (ack),
    .dc_data_i      (dc_data),
    .mem_valid_o    (valid),
    .mem_ready_i    (ready),
    .mem_data_o     (mem_data),
    .mem_rtrn_vld_i (rtrn),
    .outstanding_o  (outstanding),
    .busy_o         (busy),
    .err_o          (err)
  );

  function automatic dcache_req_t rand_req();
    dcache_req_t r;
    r.rtype = dcache_out_t'($urandom_range(0, 3));
    r.size  = 3'($urandom_range(0, 7));
    r.id    = 4'($urandom_range(0, 15));
    r.paddr = $urandom;
    r.data  = {$urandom, $urandom};
    r.nc    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic bit model_ack();
    return req && !rst && (mq.size() < DEPTH) && (mcnt < MAXO);
  endfunction

  function automatic void model_reset();
    mq.delete();
    mcnt = 0;
    merr = 1'b0;
  endfunction

  task automatic set_in(input bit r, input dcache_req_t d, input bit rd, input bit rt);
    req     = r;
    dc_data = d;
    ready   = rd;
    rtrn    = rt;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge
  task automatic tick();
    bit a;
    bit p;
    a = model_ack();
    p = (mq.size() != 0) && ready;
    @(posedge clk);
    if (p) mq.delete(0);
    if (a) mq.push_back(dc_data);
    if (a && !rtrn) mcnt++;
    else if (!a && rtrn) begin
      if (mcnt != 0) mcnt--;
      else merr = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(1'b1, rand_req(), 1'b0, 1'b0);
    n_checks++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_checks++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (outstanding !== CW'(0)) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (mem_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", mem_data); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    dcache_req_t d;
    d = rand_req();
    set_in(1'b1, d, 1'b1, 1'b0);
    n_checks++; if (ack !== 1'b1) begin n_err++; $display("FAIL single_ack: got %b want 1", ack); end
    n_checks++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b want 0", valid); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", valid); end
    n_checks++; if (mem_data !== d) begin n_err++; $display("FAIL single_data: got %h want %h", mem_data, d); end
    n_checks++; if (outstanding !== CW'(1)) begin n_err++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_inflight: got %b want 1", busy); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== CW'(0)) begin n_err++; $display("FAIL single_returned: got %0d want 0", outstanding); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    dcache_req_t d0, d1, d2;
    d0 = rand_req(); d1 = rand_req(); d2 = rand_req();
    set_in(1'b1, d0, 1'b0, 1'b0);
    n_checks++; if (ack !== 1'b1) begin n_err++; $display("FAIL bp_ack0: got %b want 1", ack); end
    tick();
    set_in(1'b1, d1, 1'b0, 1'b0);
    n_checks++; if (ack !== 1'b1) begin n_err++; $display("FAIL bp_ack1: got %b want 1", ack); end
    tick();
    set_in(1'b1, d2, 1'b0, 1'b0);
    n_checks++; if (ack !== 1'b0) begin n_err++; $display("FAIL bp_full_hold: got %b want 0", ack); end
    tick();
    set_in(1'b1, d2, 1'b1, 1'b0);
    n_checks++; if (ack !== 1'b0) begin n_err++; $display("FAIL bp_no_ready_path: got %b want 0", ack); end
    n_checks++; if (mem_data !== d0) begin n_err++; $display("FAIL bp_head0: got %h want %h", mem_data, d0); end
    tick();
    set_in(1'b1, d2, 1'b0, 1'b0);
    n_checks++; if (ack !== 1'b1) begin n_err++; $display("FAIL bp_ack2_after_pop: got %b want 1", ack); end
    n_checks++; if (mem_data !== d1) begin n_err++; $display("FAIL bp_head1: got %h want %h", mem_data, d1); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (mem_data !== d1) begin n_err++; $display("FAIL bp_head1_stable: got %h want %h", mem_data, d1); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (mem_data !== d2) begin n_err++; $display("FAIL bp_head2: got %h want %h", mem_data, d2); end
    n_checks++; if (outstanding !== CW'(3)) begin n_err++; $display("FAIL bp_outstanding: got %0d want 3", outstanding); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (outstanding !== CW'(0) || valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_drained: got out=%0d valid=%b busy=%b want 0/0/0", outstanding, valid, busy);
    end
  endtask

  task automatic test_credit_cap();
    int acks;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, rand_req(), 1'b1, 1'b0);
      if (ack === 1'b1) acks++;
      tick();
    end
    n_checks++; if (acks != 4) begin n_err++; $display("FAIL cap_acks: got %0d want 4", acks); end
    set_in(1'b1, rand_req(), 1'b1, 1'b0);
    n_checks++; if (ack !== 1'b0) begin n_err++; $display("FAIL cap_ack_blocked: got %b want 0", ack); end
    n_checks++; if (outstanding !== CW'(4)) begin n_err++; $display("FAIL cap_outstanding: got %0d want 4", outstanding); end
    set_in(1'b1, dc_data, 1'b1, 1'b1);
    tick();
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rand_req(), 1'b1, 1'b0);
      if (ack === 1'b1) acks++;
      tick();
    end
    n_checks++; if (acks != 1) begin n_err++; $display("FAIL cap_one_more: got %0d want 1", acks); end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== CW'(0) || busy !== 1'b0) begin
      n_err++; $display("FAIL cap_drained: got out=%0d busy=%b want 0/0", outstanding, busy);
    end
  endtask

  task automatic test_concurrent_err();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, rand_req(), 1'b1, 1'b0);
      tick();
    end
    set_in(1'b1, rand_req(), 1'b1, 1'b1);
    n_checks++; if (ack !== 1'b1) begin n_err++; $display("FAIL conc_ack: got %b want 1", ack); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== CW'(2)) begin n_err++; $display("FAIL conc_outstanding: got %0d want 2", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL conc_err: got %b want 0", err); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== CW'(0)) begin n_err++; $display("FAIL err_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
    tick();
    tick();
    n_checks++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_async_reset();
    dcache_req_t d;
    set_in(1'b1, rand_req(), 1'b0, 1'b0); tick();
    set_in(1'b1, rand_req(), 1'b0, 1'b0); tick();
    set_in(1'b0, '0, 1'b1, 1'b0); tick();
    set_in(1'b1, rand_req(), 1'b0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (outstanding !== CW'(3) || valid !== 1'b1) begin
      n_err++; $display("FAIL arst_setup: got out=%0d valid=%b want 3/1", outstanding, valid);
    end
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (valid !== 1'b0 || busy !== 1'b0 || outstanding !== CW'(0) || err !== 1'b0) begin
      n_err++; $display("FAIL arst_immediate: got valid=%b busy=%b out=%0d err=%b want all 0", valid, busy, outstanding, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    d = rand_req();
    set_in(1'b1, d, 1'b0, 1'b1);
    n_checks++; if (ack !== 1'b1) begin n_err++; $display("FAIL arst_first_ack: got %b want 1", ack); end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== CW'(0) || err !== 1'b0) begin
      n_err++; $display("FAIL arst_first_net: got out=%0d err=%b want 0/0", outstanding, err);
    end
    n_checks++; if (valid !== 1'b1 || mem_data !== d) begin
      n_err++; $display("FAIL arst_first_data: got valid=%b data=%h want 1/%h", valid, mem_data, d);
    end
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random_traffic();
    bit          pend;
    dcache_req_t pd;
    int          n_acc, n_ret, n_dut_ack, inflight;
    bit          r_rt;
    pend = 1'b0; pd = '0; n_acc = 0; n_ret = 0; n_dut_ack = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pd   = rand_req();
      end
      inflight = mcnt - mq.size();
      r_rt = (inflight > 0) && ($urandom_range(0, 2) == 0);
      set_in(pend, pd, $urandom_range(0, 3) != 0, r_rt);
      n_checks++; if (ack !== model_ack()) begin n_err++; $display("FAIL rnd_ack @%0d: got %b want %b", cyc, ack, model_ack()); end
      n_checks++; if (valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if (mem_data !== mq[0]) begin n_err++; $display("FAIL rnd_data @%0d: got %h want %h", cyc, mem_data, mq[0]); end
      end
      n_checks++; if (outstanding !== CW'(mcnt) || int'(outstanding) > MAXO) begin
        n_err++; $display("FAIL rnd_outstanding @%0d: got %0d want %0d", cyc, outstanding, mcnt);
      end
      n_checks++; if (busy !== ((mq.size() != 0) || (mcnt != 0))) begin n_err++; $display("FAIL rnd_busy @%0d: got %b", cyc, busy); end
      n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err @%0d: got %b want 0", cyc, err); end
      if (ack === 1'b1) n_dut_ack++;
      if (model_ack()) begin
        n_acc++;
        pend = 1'b0;
      end
      if (r_rt) n_ret++;
      tick();
    end
    for (int i = 0; i < 40 && (mcnt != 0 || mq.size() != 0); i++) begin
      inflight = mcnt - mq.size();
      r_rt = inflight > 0;
      set_in(1'b0, '0, 1'b1, r_rt);
      if (r_rt) n_ret++;
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (n_dut_ack != n_acc) begin n_err++; $display("FAIL rnd_ack_count: got %0d want %0d", n_dut_ack, n_acc); end
    n_checks++; if (outstanding !== CW'(n_acc - n_ret) || busy !== 1'b0) begin
      n_err++; $display("FAIL rnd_final: got out=%0d busy=%b want %0d/0", outstanding, busy, n_acc - n_ret);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0; dc_data = '0; ready = 1'b0; rtrn = 1'b0;
    #2;
    test_reset();
    test_single();
    test_backpressure();
    test_credit_cap();
    test_concurrent_err();
    test_async_reset();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
